mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_lane_align.sv | 48 ++++
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access controller: FSM encoding,
// access size codes, default memory size and the request legality check.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        RDCAP = 3'd2,
        MERGE = 3'd3,
        WRITE = 3'd4,
        HOLD  = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int unsigned MEM_BYTES_DEF = 128;

    // Widened to 33 bits so addresses near 2^32 cannot wrap past the limit.
    function automatic logic access_bad(input logic [1:0] sz, input logic [31:0] a,
                                        input int unsigned mem_bytes);
        logic [32:0] last_byte;
        last_byte = {1'b0, a & ~32'd3} + 33'd3;
        return (sz == SZ_ILL)
            || (sz == SZ_HALF && a[0])
            || (sz == SZ_WORD && a[1:0] != 2'b00)
            || (last_byte >= 33'(mem_bytes));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane extraction (loads) and lane merge (read-modify-write stores)
// for one 32-bit memory word; offset 0 is bits 31:24.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        sign_ext_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shift;
    logic [31:0] lane;
    logic [31:0] mask;

    always_comb begin
        shift   = '0;
        lane    = '0;
        mask    = '0;
        load_o  = word_i;
        merge_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                // (3 - offset) * 8: byte 0 lives in the top lane
                shift   = {~offset_i, 3'b000};
                mask    = 32'h0000_00FF << shift;
                lane    = (word_i >> shift) & 32'h0000_00FF;
                load_o  = (sign_ext_i && lane[7]) ? (lane | 32'hFFFF_FF00) : lane;
                merge_o = (word_i & ~mask) | ((wdata_i & 32'h0000_00FF) << shift);
            end
            SZ_HALF: begin
                shift   = {~offset_i[1], 4'b0000};
                mask    = 32'h0000_FFFF << shift;
                lane    = (word_i >> shift) & 32'h0000_FFFF;
                load_o  = (sign_ext_i && lane[15]) ? (lane | 32'hFFFF_0000) : lane;
                merge_o = (word_i & ~mask) | ((wdata_i & 32'h0000_FFFF) << shift);
            end
            default: begin
                load_o  = word_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between a CPU-side request and a level-write,
// combinational-read byte memory; sub-word stores use read-modify-write.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] DAddr,
    output logic [31:0] DataIn,
    output logic        DataMemRW,
    input  logic [31:0] DataOut
);

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] datain_q, datain_d;
    logic        err_q, err_d;

    logic        we_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        bad;
    logic [31:0] load_word;
    logic [31:0] merge_word;

    assign accept = (state_q == IDLE) && req;
    assign bad    = access_bad(size, addr, MEM_BYTES);

    mem_lane_align u_align (
        .word_i     (DataOut),
        .wdata_i    (wdata_q),
        .size_i     (size_q),
        .offset_i   (off_q),
        .sign_ext_i (sext_q),
        .load_o     (load_word),
        .merge_o    (merge_word)
    );

    // Request fields are pure data: captured on accept, never reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            we_q    <= we;
            size_q  <= size;
            sext_q  <= sign_ext;
            off_q   <= addr[1:0];
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            daddr_q  <= '0;
            datain_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            daddr_q  <= daddr_d;
            datain_q <= datain_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        daddr_d  = daddr_q;
        datain_d = datain_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (bad) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SETUP;
                        err_d   = 1'b0;
                        daddr_d = {addr[31:2], 2'b00};
                        if (we && size == SZ_WORD) begin
                            datain_d = wdata;
                        end
                    end
                end
            end
            SETUP: begin
                state_d = (we_q && size_q == SZ_WORD) ? WRITE : RDCAP;
            end
            RDCAP: begin
                // Memory word is captured here: into DataIn for a merge, into rdata for a load.
                if (we_q) begin
                    datain_d = merge_word;
                    state_d  = MERGE;
                end else begin
                    rdata_d = load_word;
                    state_d = DONE;
                end
            end
            MERGE:   state_d = WRITE;
            WRITE:   state_d = HOLD;
            HOLD:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = done && err_q;
    assign DataMemRW = (state_q == WRITE);
    assign rdata     = rdata_q;
    assign DAddr     = daddr_q;
    assign DataIn    = datain_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 128-byte big-endian memory model.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] DAddr;
    logic [31:0] DataIn;
    logic        DataMemRW;
    logic [31:0] DataOut;

    logic [7:0]  mem [0:127];
    int          errors = 0;
    int          checks = 0;
    int          wr_cnt = 0;
    int          viol   = 0;
    bit          mon_en = 1'b0;
    logic        prev_rw = 1'b0;
    logic [31:0] prev_da = '0;
    logic [31:0] prev_di = '0;

    always #5 CLK = ~CLK;

    mem_access_ctrl #(.MEM_BYTES(128)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .DAddr     (DAddr),
        .DataIn    (DataIn),
        .DataMemRW (DataMemRW),
        .DataOut   (DataOut)
    );

    always_comb begin
        DataOut = {mem[{DAddr[6:2], 2'd0}], mem[{DAddr[6:2], 2'd1}],
                   mem[{DAddr[6:2], 2'd2}], mem[{DAddr[6:2], 2'd3}]};
    end

    // Level-sensitive memory write plus address/data stability monitor.
    always @(negedge CLK) begin
        if (DataMemRW) begin
            mem[{DAddr[6:2], 2'd0}] = DataIn[31:24];
            mem[{DAddr[6:2], 2'd1}] = DataIn[23:16];
            mem[{DAddr[6:2], 2'd2}] = DataIn[15:8];
            mem[{DAddr[6:2], 2'd3}] = DataIn[7:0];
            wr_cnt++;
        end
        if (mon_en && (DataMemRW || prev_rw) && (DAddr !== prev_da || DataIn !== prev_di))
            viol++;
        prev_rw = DataMemRW;
        prev_da = DAddr;
        prev_di = DataIn;
    end

    function automatic logic [31:0] mem_word(input logic [6:0] a);
        return {mem[{a[6:2], 2'd0}], mem[{a[6:2], 2'd1}],
                mem[{a[6:2], 2'd2}], mem[{a[6:2], 2'd3}]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at a negedge back in IDLE.
    // Inputs are scrambled and req toggled while busy to prove they are ignored.
    task automatic access(input logic w, input logic [1:0] sz, input logic se,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int cyc, output logic e, output logic [31:0] da1,
                          output logic b1);
        we = w; size = sz; sign_ext = se; addr = a; wdata = wd; req = 1'b1;
        @(posedge CLK);
        #1;
        req = 1'b0; we = ~w; size = ~sz; sign_ext = ~se; addr = ~a; wdata = ~wd;
        cyc = 0; e = 1'bx; da1 = 'x; b1 = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                da1 = DAddr;
                b1  = busy;
            end
            if (done) begin
                cyc = k;
                e   = err;
                req = 1'b0;
                break;
            end
            req = ~req;
        end
        req = 1'b0;
        @(negedge CLK);
    endtask

    int          cyc;
    logic        e;
    logic        b1;
    logic [31:0] da1;
    int          w0;
    int          ndone;
    int          nidle;
    bit          got_write;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        {mem[32], mem[33], mem[34], mem[35]}     = 32'h80FF7F01;
        {mem[124], mem[125], mem[126], mem[127]} = 32'h000000A5;

        // Reset held with a legal request pending: reset must win.
        Reset = 1'b1; req = 1'b1; we = 1'b0; size = SZ_WORD; sign_ext = 1'b0;
        addr = 32'h10; wdata = '0;
        repeat (2) @(negedge CLK);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_err",    32'(err), 32'd0);
        chk("rst_rdata",  rdata, 32'h0);
        chk("rst_daddr",  DAddr, 32'h0);
        chk("rst_datain", DataIn, 32'h0);
        chk("rst_rw",     32'(DataMemRW), 32'd0);
        Reset = 1'b0; req = 1'b0;
        @(negedge CLK);
        mon_en = 1'b1;

        // Word store then word load
        w0 = wr_cnt;
        access(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, cyc, e, da1, b1);
        chk("wst_cyc",  32'(cyc), 32'd4);
        chk("wst_err",  32'(e), 32'd0);
        chk("wst_busy", 32'(b1), 32'd1);
        chk("wst_addr", da1, 32'h10);
        chk("wst_wr",   32'(wr_cnt - w0), 32'd1);
        chk("wst_mem",  mem_word(7'h10), 32'hDEADBEEF);
        w0 = wr_cnt;
        access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, cyc, e, da1, b1);
        chk("wld_cyc",   32'(cyc), 32'd3);
        chk("wld_err",   32'(e), 32'd0);
        chk("wld_rdata", rdata, 32'hDEADBEEF);
        chk("wld_wr",    32'(wr_cnt - w0), 32'd0);

        // Byte read-modify-write
        w0 = wr_cnt;
        access(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h00000055, cyc, e, da1, b1);
        chk("bst_cyc",   32'(cyc), 32'd6);
        chk("bst_err",   32'(e), 32'd0);
        chk("bst_addr",  da1, 32'h10);
        chk("bst_wr",    32'(wr_cnt - w0), 32'd1);
        chk("bst_mem",   mem_word(7'h10), 32'hDEAD55EF);
        chk("bst_rdata", rdata, 32'hDEADBEEF);

        // Lane extraction and sign extension on 0x80FF7F01
        access(1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, cyc, e, da1, b1);
        chk("lb20_s", rdata, 32'hFFFFFF80);
        access(1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, cyc, e, da1, b1);
        chk("lb20_z", rdata, 32'h00000080);
        access(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, cyc, e, da1, b1);
        chk("lh22_s", rdata, 32'h00007F01);
        access(1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, cyc, e, da1, b1);
        chk("lh20_s", rdata, 32'hFFFF80FF);
        access(1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0, cyc, e, da1, b1);
        chk("lb23_s", rdata, 32'h00000001);

        // Half and byte merges into the same word
        access(1'b1, SZ_HALF, 1'b0, 32'h22, 32'hABCD1234, cyc, e, da1, b1);
        chk("hst_cyc", 32'(cyc), 32'd6);
        chk("hst_mem", mem_word(7'h20), 32'h80FF1234);
        access(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'hFFFFFF11, cyc, e, da1, b1);
        chk("bst21_mem", mem_word(7'h20), 32'h80111234);
        access(1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, cyc, e, da1, b1);
        chk("lb21_z", rdata, 32'h00000011);

        // Highest legal byte
        access(1'b0, SZ_BYTE, 1'b1, 32'h7F, 32'h0, cyc, e, da1, b1);
        chk("lb7f_err",   32'(e), 32'd0);
        chk("lb7f_rdata", rdata, 32'hFFFFFFA5);

        // Errored accesses leave memory and rdata alone
        w0 = wr_cnt;
        access(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, cyc, e, da1, b1);
        chk("e13_cyc",   32'(cyc), 32'd1);
        chk("e13_err",   32'(e), 32'd1);
        chk("e13_rdata", rdata, 32'hFFFFFFA5);
        access(1'b0, SZ_WORD, 1'b0, 32'h7E, 32'h0, cyc, e, da1, b1);
        chk("e7e_cyc",   32'(cyc), 32'd1);
        chk("e7e_err",   32'(e), 32'd1);
        access(1'b0, SZ_ILL, 1'b0, 32'h10, 32'h0, cyc, e, da1, b1);
        chk("esz_cyc",   32'(cyc), 32'd1);
        chk("esz_err",   32'(e), 32'd1);
        access(1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0, cyc, e, da1, b1);
        chk("e80_err",   32'(e), 32'd1);
        access(1'b1, SZ_HALF, 1'b0, 32'h11, 32'h0000BBBB, cyc, e, da1, b1);
        chk("eh11_err",  32'(e), 32'd1);
        chk("eh11_mem",  mem_word(7'h10), 32'hDEAD55EF);
        chk("e_rdata",   rdata, 32'hFFFFFFA5);
        chk("e_wr",      32'(wr_cnt - w0), 32'd0);

        // Reset during WRITE of a word store
        we = 1'b1; size = SZ_WORD; sign_ext = 1'b0; addr = 32'h30; wdata = 32'h12345678; req = 1'b1;
        @(posedge CLK);
        #1;
        req = 1'b0;
        got_write = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (DataMemRW) begin
                got_write = 1'b1;
                break;
            end
        end
        chk("rmid_write", 32'(got_write), 32'd1);
        mon_en = 1'b0;
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        @(negedge CLK);
        chk("rmid_busy",  32'(busy), 32'd0);
        chk("rmid_rw",    32'(DataMemRW), 32'd0);
        chk("rmid_daddr", DAddr, 32'h0);
        chk("rmid_rdata", rdata, 32'h0);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) ndone++;
            @(negedge CLK);
        end
        chk("rmid_done", 32'(ndone), 32'd0);
        mon_en = 1'b1;

        // req held high: one accept per IDLE cycle, every fourth cycle for a word load
        we = 1'b0; size = SZ_WORD; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h0; req = 1'b1;
        ndone = 0;
        nidle = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (done) ndone++;
            if (!busy) nidle++;
            if (k == 12) req = 1'b0;
        end
        chk("b2b_done",  32'(ndone), 32'd3);
        chk("b2b_idle",  32'(nidle), 32'd3);
        chk("b2b_rdata", rdata, 32'hDEAD55EF);
        @(negedge CLK);
        chk("b2b_stop",  32'(busy), 32'd0);

        chk("proto", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
